// File: rtl/data_sram_if.sv
// Data-side SRAM request/response bundle between the EX/MEM stages and the responder.
interface data_sram_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stallreq_for_mem;
  logic        addr_err;

  modport master (
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata, stallreq_for_mem, addr_err
  );

  modport slave (
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata, stallreq_for_mem, addr_err
  );
endinterface

// File: rtl/data_sram_resp.sv
// Data SRAM responder with byte-lane writes, registered reads and optional wait states.
//   state | meaning
//   IDLE  | ready; captures a request when WAIT > 0 (WAIT = 0 accesses directly)
//   BUSY  | counting down wait states; access performed when cnt reaches 1
module data_sram_resp #(
  parameter int          ADDR_W   = 12,
  parameter int          WAIT     = 0,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  data_sram_if.slave  bus
);
  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [3:0]  req_wen_q, req_wen_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        addr_err_q, addr_err_d;

  logic              acc_go;
  logic [31:0]       acc_addr;
  logic [3:0]        acc_wen;
  logic [31:0]       acc_wdata;
  logic              acc_in_range;
  logic [ADDR_W-1:0] acc_idx;
  logic              mem_we;

  logic [31:0] mem [DEPTH];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_addr_d  = req_addr_q;
    req_wen_d   = req_wen_q;
    req_wdata_d = req_wdata_q;
    case (state_q)
      IDLE: begin
        if ((WAIT != 0) && bus.data_sram_en) begin
          req_addr_d  = bus.data_sram_addr;
          req_wen_d   = bus.data_sram_wen;
          req_wdata_d = bus.data_sram_wdata;
          cnt_d       = WAIT_CNT;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q > 4'd1) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // With no wait states the live request is the access; otherwise the captured one.
  always_comb begin
    if (WAIT == 0) begin
      acc_go    = bus.data_sram_en;
      acc_addr  = bus.data_sram_addr;
      acc_wen   = bus.data_sram_wen;
      acc_wdata = bus.data_sram_wdata;
    end else begin
      acc_go    = (state_q == BUSY) && (cnt_q == 4'd1);
      acc_addr  = req_addr_q;
      acc_wen   = req_wen_q;
      acc_wdata = req_wdata_q;
    end
    acc_in_range = (acc_addr >> (ADDR_W + 2)) == 32'd0;
    acc_idx      = acc_addr[ADDR_W+1:2];
    mem_we       = acc_go && (acc_wen != 4'd0) && acc_in_range && !rst;

    rdata_d = rdata_q;
    if (acc_go && (acc_wen == 4'd0)) begin
      rdata_d = acc_in_range ? mem[acc_idx] : ERR_DATA;
    end
    addr_err_d = addr_err_q | (acc_go & ~acc_in_range);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      req_addr_q  <= 32'd0;
      req_wen_q   <= 4'd0;
      req_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_addr_q  <= req_addr_d;
      req_wen_q   <= req_wen_d;
      req_wdata_q <= req_wdata_d;
      rdata_q     <= rdata_d;
      addr_err_q  <= addr_err_d;
    end
  end

  // Array is deliberately not reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wen[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  assign bus.data_sram_rdata  = rdata_q;
  assign bus.stallreq_for_mem = (state_q == BUSY);
  assign bus.addr_err         = addr_err_q;
endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench: one zero-wait and one three-wait-state responder side by side.
module tb_data_sram_resp;
  logic clk = 1'b0;
  logic rst0, rst3;
  int   total = 0;
  int   bad   = 0;

  data_sram_if i0 ();
  data_sram_if i3 ();

  data_sram_resp #(.ADDR_W(12), .WAIT(0)) dut0 (.clk(clk), .rst(rst0), .bus(i0));
  data_sram_resp #(.ADDR_W(12), .WAIT(3)) dut3 (.clk(clk), .rst(rst3), .bus(i3));

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive0(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wdata);
    i0.data_sram_en    = en;
    i0.data_sram_wen   = wen;
    i0.data_sram_addr  = addr;
    i0.data_sram_wdata = wdata;
  endtask

  task automatic drive3(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wdata);
    i3.data_sram_en    = en;
    i3.data_sram_wen   = wen;
    i3.data_sram_addr  = addr;
    i3.data_sram_wdata = wdata;
  endtask

  // One isolated WAIT=3 access: stall for three cycles, then idle with exp_rd on rdata.
  task automatic acc3(input string tag, input logic [3:0] wen, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rd);
    drive3(1'b1, wen, addr, wdata);
    step();
    i3.data_sram_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check({tag, "_stall"}, {31'd0, i3.stallreq_for_mem}, 32'd1);
      step();
    end
    check({tag, "_done"}, {31'd0, i3.stallreq_for_mem}, 32'd0);
    check({tag, "_rdata"}, i3.data_sram_rdata, exp_rd);
  endtask

  initial begin
    rst0 = 1'b1;
    rst3 = 1'b1;
    drive0(1'b0, 4'h0, 32'h0, 32'h0);
    drive3(1'b0, 4'h0, 32'h0, 32'h0);
    step();
    step();
    check("rst0_rdata", i0.data_sram_rdata, 32'h0);
    check("rst0_stall", {31'd0, i0.stallreq_for_mem}, 32'd0);
    check("rst0_err",   {31'd0, i0.addr_err}, 32'd0);
    check("rst3_rdata", i3.data_sram_rdata, 32'h0);
    check("rst3_stall", {31'd0, i3.stallreq_for_mem}, 32'd0);
    check("rst3_err",   {31'd0, i3.addr_err}, 32'd0);
    rst0 = 1'b0;
    rst3 = 1'b0;
    step();

    // WAIT=0: full word then byte-lane merges
    drive0(1'b1, 4'hF, 32'h40, 32'h1234_5678);
    step();
    check("w0_stall_wr", {31'd0, i0.stallreq_for_mem}, 32'd0);
    check("w0_hold_wr",  i0.data_sram_rdata, 32'h0);
    drive0(1'b1, 4'h0, 32'h40, 32'h0);
    step();
    check("w0_rd_full",  i0.data_sram_rdata, 32'h1234_5678);
    check("w0_stall_rd", {31'd0, i0.stallreq_for_mem}, 32'd0);
    drive0(1'b1, 4'b0010, 32'h41, 32'hABAB_ABAB);
    step();
    check("w0_hold_lane", i0.data_sram_rdata, 32'h1234_5678);
    drive0(1'b1, 4'h0, 32'h40, 32'h0);
    step();
    check("w0_rd_lane1", i0.data_sram_rdata, 32'h1234_AB78);
    drive0(1'b1, 4'b1100, 32'h40, 32'hCDEF_CDEF);
    step();
    drive0(1'b1, 4'h0, 32'h40, 32'h0);
    step();
    check("w0_rd_lane32", i0.data_sram_rdata, 32'hCDEF_AB78);

    // WAIT=0: out-of-range aliasing onto word 0 must not write
    drive0(1'b1, 4'hF, 32'h0, 32'h1122_3344);
    step();
    check("w0_err_clear", {31'd0, i0.addr_err}, 32'd0);
    drive0(1'b1, 4'hF, 32'h0001_0000, 32'h5555_5555);
    step();
    check("w0_err_set", {31'd0, i0.addr_err}, 32'd1);
    drive0(1'b1, 4'h0, 32'h0, 32'h0);
    step();
    check("w0_oor_nowr", i0.data_sram_rdata, 32'h1122_3344);
    drive0(1'b1, 4'h0, 32'h0001_0000, 32'h0);
    step();
    check("w0_oor_rd", i0.data_sram_rdata, 32'hDEAD_BEEF);
    drive0(1'b1, 4'h0, 32'h40, 32'h0);
    step();
    check("w0_rd_after_oor", i0.data_sram_rdata, 32'hCDEF_AB78);
    check("w0_err_sticky", {31'd0, i0.addr_err}, 32'd1);

    // WAIT=0: reset beats a simultaneous write; memory survives reset
    drive0(1'b1, 4'hF, 32'h8, 32'hAAAA_0000);
    step();
    rst0 = 1'b1;
    drive0(1'b1, 4'hF, 32'h8, 32'h9999_9999);
    step();
    check("w0_rst_rdata", i0.data_sram_rdata, 32'h0);
    check("w0_rst_err",   {31'd0, i0.addr_err}, 32'd0);
    rst0 = 1'b0;
    drive0(1'b1, 4'h0, 32'h8, 32'h0);
    step();
    check("w0_rst_en_ignored", i0.data_sram_rdata, 32'hAAAA_0000);
    drive0(1'b1, 4'h0, 32'h0, 32'h0);
    step();
    check("w0_mem_survives", i0.data_sram_rdata, 32'h1122_3344);
    drive0(1'b0, 4'h0, 32'h0, 32'h0);

    // WAIT=3: preload
    acc3("w3_pre", 4'hF, 32'h100, 32'hCAFE_F00D, 32'h0);

    // WAIT=3: read held under stall, then back-to-back write with no bubble
    drive3(1'b1, 4'h0, 32'h100, 32'h0);
    step();
    check("w3_b2b_s1", {31'd0, i3.stallreq_for_mem}, 32'd1);
    check("w3_b2b_rd_early", i3.data_sram_rdata, 32'h0);
    step();
    check("w3_b2b_s2", {31'd0, i3.stallreq_for_mem}, 32'd1);
    step();
    check("w3_b2b_s3", {31'd0, i3.stallreq_for_mem}, 32'd1);
    check("w3_b2b_rd_late", i3.data_sram_rdata, 32'h0);
    step();
    check("w3_b2b_idle", {31'd0, i3.stallreq_for_mem}, 32'd0);
    check("w3_b2b_rdata", i3.data_sram_rdata, 32'hCAFE_F00D);
    drive3(1'b1, 4'hF, 32'h104, 32'h0102_0304);
    step();
    check("w3_b2b2_s1", {31'd0, i3.stallreq_for_mem}, 32'd1);
    step();
    check("w3_b2b2_s2", {31'd0, i3.stallreq_for_mem}, 32'd1);
    step();
    check("w3_b2b2_s3", {31'd0, i3.stallreq_for_mem}, 32'd1);
    i3.data_sram_en = 1'b0;
    step();
    check("w3_b2b2_idle", {31'd0, i3.stallreq_for_mem}, 32'd0);
    check("w3_b2b2_hold", i3.data_sram_rdata, 32'hCAFE_F00D);

    // WAIT=3: request inputs changing while BUSY are ignored
    drive3(1'b1, 4'hF, 32'h108, 32'h1111_1111);
    step();
    drive3(1'b1, 4'h0, 32'h104, 32'hFFFF_FFFF);
    step();
    step();
    i3.data_sram_en = 1'b0;
    step();
    check("w3_ign_idle", {31'd0, i3.stallreq_for_mem}, 32'd0);
    check("w3_ign_no_rd", i3.data_sram_rdata, 32'hCAFE_F00D);
    acc3("w3_ign_rd108", 4'h0, 32'h108, 32'h0, 32'h1111_1111);
    acc3("w3_ign_rd104", 4'h0, 32'h104, 32'h0, 32'h0102_0304);

    // WAIT=3: reset while BUSY drops the pending write
    drive3(1'b1, 4'hF, 32'h100, 32'h0BAD_C0DE);
    step();
    i3.data_sram_en = 1'b0;
    step();
    rst3 = 1'b1;
    step();
    check("w3_rst_stall", {31'd0, i3.stallreq_for_mem}, 32'd0);
    check("w3_rst_rdata", i3.data_sram_rdata, 32'h0);
    rst3 = 1'b0;
    step();
    check("w3_rst_idle", {31'd0, i3.stallreq_for_mem}, 32'd0);
    acc3("w3_rst_old", 4'h0, 32'h100, 32'h0, 32'hCAFE_F00D);

    // WAIT=3: out-of-range read
    check("w3_err_clear", {31'd0, i3.addr_err}, 32'd0);
    acc3("w3_oor", 4'h0, 32'h0001_0000, 32'h0, 32'hDEAD_BEEF);
    check("w3_err_set", {31'd0, i3.addr_err}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
